// File: rtl/display_scan_mux_if.sv
// Bus between a display controller and the four-digit scan multiplexer.
// The master drives the value and display controls; the slave returns the digit drive.
interface display_scan_mux_if;
    logic        load;
    logic [15:0] value;
    logic        blank;
    logic        lzs;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic        frame_done;

    modport master (
        output load, value, blank, lzs,
        input  digit, an, frame_done
    );

    modport slave (
        input  load, value, blank, lzs,
        output digit, an, frame_done
    );
endinterface

// File: rtl/display_scan_mux.sv
// Four-digit seven-segment scanner: steps through the hex nibbles of a double-buffered
// 16-bit value, holding each digit for PRESCALE cycles.
module display_scan_mux #(
    parameter int unsigned PRESCALE = 4
) (
    input logic               clk,
    input logic               rst,
    display_scan_mux_if.slave bus
);

    localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     pend_q, pend_d;
    logic [15:0]     act_q, act_d;
    logic            pvalid_q, pvalid_d;

    logic            step_end;
    logic            wrap;
    logic [15:0]     act_shift;
    logic            suppressed;

    always_comb begin
        step_end = (cnt_q == CntMax);
        wrap     = step_end && (idx_q == 2'd3);
        cnt_d    = step_end ? '0 : cnt_q + CntW'(1);
        idx_d    = step_end ? idx_q + 2'd1 : idx_q;
        pend_d   = bus.load ? bus.value : pend_q;
        act_d    = act_q;
        pvalid_d = pvalid_q | bus.load;
        // A load landing on the wrap edge bypasses pend and supersedes any older pending value.
        if (wrap) begin
            if (bus.load) begin
                act_d = bus.value;
            end else if (pvalid_q) begin
                act_d = pend_q;
            end
            pvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            pend_q   <= 16'h0000;
            act_q    <= 16'h0000;
            pvalid_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            act_q    <= act_d;
            pvalid_q <= pvalid_d;
        end
    end

    // The current digit and everything above it sit in the low bits after the shift.
    assign act_shift  = act_q >> {idx_q, 2'b00};
    assign suppressed = bus.lzs && (idx_q != 2'd0) && (act_shift == 16'h0000);

    assign bus.digit      = act_shift[3:0];
    assign bus.an         = (bus.blank || suppressed) ? 4'b0000 : (4'b0001 << idx_q);
    assign bus.frame_done = wrap;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: directed vector table and hand sequences on PRESCALE=2,
// plus randomized traffic on PRESCALE=2/1/3 checked against a frame-level reference model.
module tb_display_scan_mux;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        blank;
    logic        lzs;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    display_scan_mux_if bus_a ();
    display_scan_mux_if bus_b ();
    display_scan_mux_if bus_c ();

    assign bus_a.load = load;
    assign bus_a.value = value;
    assign bus_a.blank = blank;
    assign bus_a.lzs = lzs;
    assign bus_b.load = load;
    assign bus_b.value = value;
    assign bus_b.blank = blank;
    assign bus_b.lzs = lzs;
    assign bus_c.load = load;
    assign bus_c.value = value;
    assign bus_c.blank = blank;
    assign bus_c.lzs = lzs;

    display_scan_mux #(.PRESCALE(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    display_scan_mux #(.PRESCALE(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    display_scan_mux #(.PRESCALE(3)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    logic [8:0] dut_out [3];
    assign dut_out[0] = {bus_a.digit, bus_a.an, bus_a.frame_done};
    assign dut_out[1] = {bus_b.digit, bus_b.an, bus_b.frame_done};
    assign dut_out[2] = {bus_c.digit, bus_c.an, bus_c.frame_done};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got digit/an/fd=%h/%b/%b expected %h/%b/%b", name,
                     got[8:5], got[4:1], got[0], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Position within a PRESCALE=2 frame, counted from the last reset release.
    task automatic goto_pos(input int p);
        for (int i = 0; i < 8 && (cyc % 8) != p; i++) step();
    endtask

    // Reference model: elapsed cycles since reset fix the scan position; a frame shows the
    // last value loaded during the previous frame (the wrap edge included).
    int unsigned pre [3] = '{2, 1, 3};
    int unsigned t_m [3] = '{0, 0, 0};
    logic [15:0] act_m [3] = '{16'h0, 16'h0, 16'h0};
    logic [15:0] last_m [3] = '{16'h0, 16'h0, 16'h0};
    bit          seen_m [3] = '{0, 0, 0};

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            for (int k = 0; k < 3; k++) begin
                if (rst) begin
                    t_m[k]    = 0;
                    act_m[k]  = 16'h0;
                    seen_m[k] = 0;
                end else begin
                    if (load) begin
                        last_m[k] = value;
                        seen_m[k] = 1;
                    end
                    if ((t_m[k] + 1) % (4 * pre[k]) == 0) begin
                        if (seen_m[k]) act_m[k] = last_m[k];
                        seen_m[k] = 0;
                    end
                    t_m[k]++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                int unsigned pos;
                logic [15:0] rest;
                logic [3:0]  an_e;
                pos  = (t_m[k] / pre[k]) % 4;
                rest = act_m[k] >> (4 * pos);
                if (blank || (lzs && pos != 0 && rest == 16'h0)) an_e = 4'b0000;
                else an_e = 4'b0001 << pos;
                chk($sformatf("model_p%0d_t%0d", pre[k], t_m[k]), dut_out[k],
                    {rest[3:0], an_e, (t_m[k] % (4 * pre[k])) == (4 * pre[k] - 1)});
            end
        end
    end

    typedef struct {
        logic        load;
        logic [15:0] value;
        logic        blank;
        logic        lzs;
        logic [8:0]  exp;
    } vec_t;

    vec_t vecs[$];

    logic [15:0] ld_val [4] = '{16'hA5C3, 16'h0040, 16'h0000, 16'hFFFF};
    logic [31:0] fr_dig [6] = '{32'h0, 32'h33CC55AA, 32'h00440000, 32'h0, 32'hFFFFFFFF,
                                32'hFFFFFFFF};
    logic [31:0] fr_an [6] = '{32'h11224488, 32'h11224488, 32'h11220000, 32'h11000000, 32'h0,
                               32'h11224488};
    bit          fr_lzs [6] = '{0, 0, 1, 1, 0, 0};
    bit          fr_blank [6] = '{0, 0, 0, 0, 1, 0};
    logic [31:0] beef_dig = 32'hFFEEEEBB;
    logic [31:0] beef_an = 32'h11224488;
    logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = 16'h0;
        blank = 1'b0;
        lzs   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        // Reset mid-frame with act=1234 and a pending load that must be lost.
        load = 1'b1; value = 16'h1234;
        step();
        load = 1'b0;
        goto_pos(0);
        goto_pos(3);
        chk("pre_reset", dut_out[0], {4'h3, 4'b0010, 1'b0});
        load = 1'b1; value = 16'h9999;
        step();
        load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("reset_async", dut_out[0], {4'h0, 4'b0001, 1'b0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        chk("rst_hold0", dut_out[0], {4'h0, 4'b0001, 1'b0});
        step();
        chk("rst_hold1", dut_out[0], {4'h0, 4'b0001, 1'b0});
        step();
        chk("rst_adv", dut_out[0], {4'h0, 4'b0010, 1'b0});
        goto_pos(0);
        chk("pend_lost", dut_out[0], {4'h0, 4'b0001, 1'b0});

        // Vector table: scan order, leading-zero suppression, blanking, from a fresh reset.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        for (int f = 0; f < 6; f++) begin
            for (int c = 0; c < 8; c++) begin
                vec_t v;
                v.load  = 1'b0;
                v.value = 16'h0;
                if (f < 4 && c == 0) begin
                    v.load  = 1'b1;
                    v.value = ld_val[f];
                end
                v.blank = fr_blank[f];
                v.lzs   = fr_lzs[f];
                v.exp   = {fr_dig[f][31-4*c -: 4], fr_an[f][31-4*c -: 4], c == 7};
                vecs.push_back(v);
            end
        end
        foreach (vecs[i]) begin
            load  = vecs[i].load;
            value = vecs[i].value;
            blank = vecs[i].blank;
            lzs   = vecs[i].lzs;
            #1;
            chk($sformatf("vec%0d", i), dut_out[0], vecs[i].exp);
            step();
        end
        load = 1'b0; blank = 1'b0; lzs = 1'b0;

        // Double buffering: a load at idx=2 waits for the next frame.
        load = 1'b1; value = 16'h1111;
        step();
        load = 1'b0;
        goto_pos(0);
        goto_pos(4);
        load = 1'b1; value = 16'h2222;
        #1;
        chk("dbuf_idx2a", dut_out[0], {4'h1, 4'b0100, 1'b0});
        step();
        load = 1'b0;
        chk("dbuf_idx2b", dut_out[0], {4'h1, 4'b0100, 1'b0});
        step();
        chk("dbuf_idx3a", dut_out[0], {4'h1, 4'b1000, 1'b0});
        step();
        chk("dbuf_idx3b", dut_out[0], {4'h1, 4'b1000, 1'b1});
        step();
        chk("dbuf_new", dut_out[0], {4'h2, 4'b0001, 1'b0});

        // Load on the wrap edge overrides an older pending value.
        goto_pos(2);
        load = 1'b1; value = 16'h5555;
        step();
        load = 1'b0;
        goto_pos(7);
        load = 1'b1; value = 16'hBEEF;
        #1;
        chk("wrap_fd", dut_out[0], {4'h2, 4'b1000, 1'b1});
        step();
        load = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("wrap_load%0d", c), dut_out[0],
                {beef_dig[31-4*c -: 4], beef_an[31-4*c -: 4], c == 7});
            step();
        end
        chk("no_stale", dut_out[0], {4'hF, 4'b0001, 1'b0});

        // PRESCALE=1: idx advances every edge, frame_done whenever idx=3.
        for (int c = 0; c < 12; c++) begin
            logic [3:0] an_e;
            blank = (c >= 8);
            an_e  = blank ? 4'b0000 : (4'b0001 << (cyc % 4));
            #1;
            chk($sformatf("p1_c%0d", c), {4'h0, dut_out[1][4:0]},
                {4'h0, an_e, (cyc % 4) == 3});
            step();
        end
        blank = 1'b0;

        // Randomized traffic; the negedge monitor compares all three instances.
        for (int i = 0; i < 600; i++) begin
            load  = ($urandom_range(3) == 0);
            value = 16'($urandom) & masks[$urandom_range(4)];
            blank = ($urandom_range(7) == 0);
            lzs   = 1'($urandom_range(1));
            if (i == 300) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_mux.md
# display_scan_mux

Time-multiplexing scanner for a four-digit seven-segment display. It holds a 16-bit value as four hex nibbles and steps through them, one digit at a time. Each step drives one nibble onto the 4-bit binary input of the downstream binary-to-seven-segment converter, together with a one-hot digit-enable. New values are double-buffered so a displayed frame never mixes old and new digits.

## Interface

Parameters:
- PRESCALE, default 4: clock cycles each digit is held. Legal range is 1..65535.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- load  input  1  capture `value` into the pending register this edge
- value  input  16  display value; nibble i = value[4i+3:4i], digit 0 = least significant
- blank  input  1  force all digit enables low; scanning continues
- lzs  input  1  leading-zero suppression enable
- digit  output  4  nibble for the current digit; connects to the converter's `in`
- an  output  4  one-hot active-high digit enable; bit i = digit i
- frame_done  output  1  high during the last cycle of each frame

## Operation

State:
- cnt: prescale counter, 0..PRESCALE-1.
- idx: 2-bit digit index.
- pend: 16-bit pending value.
- act: 16-bit active value.
- pvalid: 1-bit pending-valid flag.

Reset (async, immediate): cnt=0, idx=0, pend=0, act=0, pvalid=0. Outputs therefore read digit=4'h0, an=4'b0001 (when blank=0), frame_done=0 (PRESCALE>1) or 0 (idx=0).

Each clock edge:
- cnt increments. At PRESCALE-1, cnt wraps to 0 and idx increments mod 4. With PRESCALE=1, idx advances every edge.
- Wrap edge: idx goes 3->0 and cnt goes PRESCALE-1->0.
  - If pvalid=1, then act<=pend and pvalid<=0.
- load=1: pend<=value and pvalid<=1.
  - If load coincides with a wrap edge, act<=value directly and pvalid<=0. An older pending value is discarded.
- Multiple loads within one frame: last wins.

Outputs are combinational from state and inputs (Moore, except blank/lzs):
- digit = act[4*idx+3 : 4*idx]. Unaffected by blank and lzs.
- an = blank ? 0 : (suppressed ? 0 : one-hot(idx)).
- suppressed = lzs && idx!=0 && act[15:4*idx]==0. Digit 0 is never suppressed, so value 0 shows a single "0".
- frame_done = (idx==3 && cnt==PRESCALE-1).

## Timing

- Each digit is presented for exactly PRESCALE cycles. A frame is 4*PRESCALE cycles.
- Load-to-display latency: the value appears at the start of the next frame. That is 1 cycle minimum (load on the wrap edge) and 4*PRESCALE cycles maximum.
- act changes only on a wrap edge, so digit never shows a mix of two values within a frame.
- blank and lzs take effect combinationally in the same cycle. They do not alter cnt, idx, or any registers.
- Reset asserted mid-frame returns to the reset state immediately. pvalid is cleared and a pending load is lost. After deassertion, the first edge advances cnt from 0.
- No handshake backpressure. load is always accepted.

## Test plan

All scenarios use PRESCALE=2 unless noted.
- Reset: assert rst mid-frame with act=16'h1234 -> immediately digit=0, an=4'b0001, frame_done=0. After release, idx stays 0 for 2 cycles.
- Scan order: load 16'hA5C3 during reset-released frame 0, then wait for the wrap. The next 8 cycles show digit/an = 3/0001, 3/0001, C/0010, C/0010, 5/0100, 5/0100, A/1000, A/1000. frame_done is high only in the 8th cycle.
- Double buffering: mid-frame (idx=2) with act=16'h1111, load 16'h2222 -> idx 2..3 still show 1. The first cycle after the wrap shows digit=2. pvalid is cleared.
- Load on wrap edge: load 16'hBEEF exactly on the frame_done cycle edge, with a different older pend -> next cycle digit=F, and subsequent digits E, E, B. The older pend is never displayed.
- Leading-zero suppression: act=16'h0040, lzs=1 -> an = 0001, 0010, 0000, 0000 across the frame, with digit values still 0, 4, 0, 0. act=0, lzs=1 -> only an=0001 is asserted.
- Blank and PRESCALE=1: blank=1 -> an=0 every cycle, idx keeps advancing, and frame_done pulses every 4 cycles. With PRESCALE=1, idx advances every edge and frame_done is high whenever idx=3.
